// File: rtl/merge_pkt_pkg.sv
// Shared types, header field offsets and default header constants for the
// merge-stage packet framer.
package merge_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    localparam int HDR_W           = 256;
    localparam int HDR_MAGIC_LSB   = 240;
    localparam int HDR_VERSION_LSB = 232;
    localparam int HDR_BEATS_LSB   = 224;
    localparam int HDR_SEQ_LSB     = 192;
    localparam int HDR_TS_LSB      = 128;
    localparam int HDR_ESHORT_LSB  = 112;
    localparam int HDR_ELONG_LSB   = 96;

    localparam logic [15:0] DEF_HDR_MAGIC   = 16'hA55A;
    localparam logic [7:0]  DEF_HDR_VERSION = 8'h01;

    function automatic logic [HDR_W-1:0] build_header(
        input logic [15:0] magic,
        input logic [7:0]  version,
        input logic [7:0]  beats,
        input logic [31:0] seq,
        input logic [63:0] ts,
        input logic [15:0] err_short,
        input logic [15:0] err_long
    );
        logic [HDR_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_MAGIC_LSB   +: 16] = magic;
        hdr[HDR_VERSION_LSB +: 8]  = version;
        hdr[HDR_BEATS_LSB   +: 8]  = beats;
        hdr[HDR_SEQ_LSB     +: 32] = seq;
        hdr[HDR_TS_LSB      +: 64] = ts;
        hdr[HDR_ESHORT_LSB  +: 16] = err_short;
        hdr[HDR_ELONG_LSB   +: 16] = err_long;
        return hdr;
    endfunction

endpackage

// File: rtl/merge_pkt_framer_if.sv
// AXI-Stream bundle used for both the merged input and the framed output.
interface merge_pkt_framer_if #(
    parameter int DATA_W = 256
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/merge_pkt_framer.sv
// Prepends a header beat to each merged packet and enforces a fixed payload
// length, trimming overruns and flagging short packets.
module merge_pkt_framer
    import merge_pkt_pkg::*;
#(
    parameter int          PKT_BEATS   = 16,
    parameter logic [15:0] HDR_MAGIC   = DEF_HDR_MAGIC,
    parameter logic [7:0]  HDR_VERSION = DEF_HDR_VERSION
) (
    input  logic               axis_aclk,
    input  logic               axis_rst,
    input  logic               enable,
    merge_pkt_framer_if.slave  s_axis,
    merge_pkt_framer_if.master m_axis,
    output logic [31:0]        seq_num,
    output logic [15:0]        err_short_cnt,
    output logic [15:0]        err_long_cnt,
    output logic               busy
);

    localparam logic [7:0] LAST_BEAT   = 8'(PKT_BEATS - 1);
    localparam logic [7:0] BEATS_FIELD = 8'(PKT_BEATS);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       beat_cnt_q;
    logic [63:0]      ts_q;
    logic [31:0]      seq_q;
    logic [15:0]      err_short_q;
    logic [15:0]      err_long_q;
    logic             m_valid_q;
    logic             m_last_q;
    logic [HDR_W-1:0] m_data_q;

    logic out_free;
    logic at_last;
    logic hdr_load;
    logic pay_accept;
    logic short_end;
    logic long_end;
    logic pkt_end;
    logic s_ready;

    assign out_free = !m_valid_q || m_axis.tready;
    assign at_last  = (beat_cnt_q == LAST_BEAT);
    assign pkt_end  = pay_accept && (s_axis.tlast || at_last);

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        state_d    = state_q;
        hdr_load   = 1'b0;
        pay_accept = 1'b0;
        short_end  = 1'b0;
        long_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && s_axis.tvalid && out_free) begin
                    hdr_load = 1'b1;
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (s_axis.tvalid && out_free) begin
                    pay_accept = 1'b1;
                    if (s_axis.tlast) begin
                        short_end = !at_last;
                        state_d   = IDLE;
                    end else if (at_last) begin
                        long_end = 1'b1;
                        state_d  = DROP;
                    end
                end
            end
            DROP: begin
                if (s_axis.tvalid && s_axis.tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Readiness passes straight through from the output side while framing.
    always_comb begin
        s_ready = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            PAYLOAD: s_ready = out_free;
            DROP:    s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples the pre-edge values of the others.
    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            ts_q        <= '0;
            beat_cnt_q  <= '0;
            seq_q       <= '0;
            err_short_q <= '0;
            err_long_q  <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
        end else begin
            ts_q <= ts_q + 64'd1;

            if (out_free) begin
                if (hdr_load) begin
                    m_valid_q <= 1'b1;
                    m_last_q  <= 1'b0;
                    m_data_q  <= build_header(HDR_MAGIC, HDR_VERSION, BEATS_FIELD, seq_q,
                                              ts_q, err_short_q, err_long_q);
                end else if (pay_accept) begin
                    m_valid_q <= 1'b1;
                    m_last_q  <= s_axis.tlast || at_last;
                    m_data_q  <= s_axis.tdata;
                end else begin
                    m_valid_q <= 1'b0;
                end
            end

            if (hdr_load)        beat_cnt_q <= '0;
            else if (pay_accept) beat_cnt_q <= beat_cnt_q + 8'd1;

            if (pkt_end) seq_q <= seq_q + 32'd1;

            // Error counters stick at all-ones rather than wrapping.
            if (short_end && (err_short_q != 16'hFFFF)) err_short_q <= err_short_q + 16'd1;
            if (long_end && (err_long_q != 16'hFFFF))   err_long_q  <= err_long_q + 16'd1;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tdata  = m_data_q;
    assign seq_num       = seq_q;
    assign err_short_cnt = err_short_q;
    assign err_long_cnt  = err_long_q;

endmodule

// File: tb/tb_merge_pkt_framer.sv
// Directed and randomized bench for merge_pkt_framer, checked against a
// frame-level reference model built from the header/length rules.
module tb_merge_pkt_framer;

    localparam int PKT_BEATS = 16;
    localparam int TIMEOUT   = 2000;

    logic        axis_aclk = 1'b0;
    logic        axis_rst;
    logic        enable;
    logic [31:0] seq_num;
    logic [15:0] err_short_cnt;
    logic [15:0] err_long_cnt;
    logic        busy;

    merge_pkt_framer_if s_if ();
    merge_pkt_framer_if m_if ();

    always #5 axis_aclk = ~axis_aclk;

    merge_pkt_framer dut (
        .axis_aclk     (axis_aclk),
        .axis_rst      (axis_rst),
        .enable        (enable),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .seq_num       (seq_num),
        .err_short_cnt (err_short_cnt),
        .err_long_cnt  (err_long_cnt),
        .busy          (busy)
    );

    typedef struct {
        logic [255:0]    data;
        logic            last;
        longint unsigned cyc;
    } obs_t;

    typedef struct {
        logic [255:0] data;
        logic         last;
        bit           hdr;
    } exp_t;

    obs_t            out_q[$];
    exp_t            exp_q[$];
    logic [63:0]     hdr_ts[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              n_fail   = 0;
    bit              aborted  = 0;
    int              ready_mode = 0;
    longint unsigned cyc = 0;
    longint unsigned present_cyc = 0;
    logic [31:0]     m_seq;
    logic [15:0]     m_short;
    logic [15:0]     m_long;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference timestamp: cleared by a reset edge, +1 on every other edge.
    initial begin
        forever begin
            @(posedge axis_aclk);
            if (axis_rst) cyc = 0;
            else          cyc++;
        end
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge axis_aclk);
            #1;
            m_if.tready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records accepted beats and checks hold-while-stalled.
    initial begin
        logic         prev_stall;
        logic [255:0] prev_data;
        logic         prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge axis_aclk);
            if (axis_rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 256'(m_if.tvalid), 256'(1));
                    check("stall_data", m_if.tdata, prev_data);
                    check("stall_last", 256'(m_if.tlast), 256'(prev_last));
                end else if (m_if.tvalid) begin
                    present_cyc = cyc;
                end
                if (m_if.tvalid && m_if.tready) begin
                    out_q.push_back('{m_if.tdata, m_if.tlast, present_cyc});
                    prev_stall = 1'b0;
                end else if (m_if.tvalid) begin
                    prev_stall = 1'b1;
                    prev_data  = m_if.tdata;
                    prev_last  = m_if.tlast;
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [255:0] d, input logic l);
        int t;
        if (aborted) return;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        t = 0;
        while (1) begin
            @(negedge axis_aclk);
            if (s_if.tready) break;
            t++;
            if (t > TIMEOUT) begin
                check("send_timeout", 256'(s_if.tready), 256'(1));
                aborted = 1;
                return;
            end
        end
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Sends an n-beat packet with tlast on its final beat and appends the
    // frame the framer should emit for it to the expected queue.
    task automatic send_pkt(input int n, input bit rnd, input int en_off_at);
        logic [255:0] d;
        exp_t         e;
        e.data = {16'hA55A, 8'h01, 8'(PKT_BEATS), m_seq, 64'h0, m_short, m_long, 96'h0};
        e.last = 1'b0;
        e.hdr  = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
            end else begin
                d = 256'(i);
            end
            if (i < PKT_BEATS) begin
                e.data = d;
                e.last = (i == n - 1) || (i == PKT_BEATS - 1);
                e.hdr  = 1'b0;
                exp_q.push_back(e);
            end
            if (i == en_off_at) enable = 1'b0;
            send_beat(d, i == n - 1);
        end
        if (n < PKT_BEATS) begin
            if (m_short != 16'hFFFF) m_short++;
        end else if (n > PKT_BEATS) begin
            if (m_long != 16'hFFFF) m_long++;
        end
        m_seq++;
    endtask

    task automatic drain(input string tag, output int n_last);
        int   t;
        obs_t o;
        exp_t e;
        t = 0;
        while ((out_q.size() < exp_q.size()) && (t < TIMEOUT)) begin
            @(negedge axis_aclk);
            t++;
        end
        repeat (4) @(negedge axis_aclk);
        check({tag, "_beats"}, 256'(out_q.size()), 256'(exp_q.size()));
        n_last = 0;
        while ((out_q.size() > 0) && (exp_q.size() > 0)) begin
            o = out_q.pop_front();
            e = exp_q.pop_front();
            if (e.hdr) begin
                check({tag, "_hdr"}, 256'({o.data[255:192], o.data[127:0]}),
                      256'({e.data[255:192], e.data[127:0]}));
                check({tag, "_hdr_ts"}, 256'(o.data[191:128]), 256'(o.cyc - 1));
                hdr_ts.push_back(o.data[191:128]);
            end else begin
                check({tag, "_data"}, o.data, e.data);
            end
            check({tag, "_last"}, 256'(o.last), 256'(e.last));
            if (o.last) n_last++;
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int nl;
        axis_rst    = 1'b1;
        enable      = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_seq       = '0;
        m_short     = '0;
        m_long      = '0;
        repeat (3) @(posedge axis_aclk);
        #1;
        axis_rst = 1'b0;

        @(negedge axis_aclk);
        check("rst_m_tvalid", 256'(m_if.tvalid), 256'(0));
        check("rst_m_tlast", 256'(m_if.tlast), 256'(0));
        check("rst_m_tdata", m_if.tdata, 256'(0));
        check("rst_s_tready", 256'(s_if.tready), 256'(0));
        check("rst_seq", 256'(seq_num), 256'(0));
        check("rst_err", 256'({err_short_cnt, err_long_cnt}), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        @(posedge axis_aclk);
        #1;

        // Two back-to-back nominal packets at full throughput.
        enable = 1'b1;
        hdr_ts.delete();
        send_pkt(16, 1'b0, -1);
        send_pkt(16, 1'b0, -1);
        idle();
        drain("t1", nl);
        check("t1_tlasts", 256'(nl), 256'(2));
        check("t1_hdr_count", 256'(hdr_ts.size()), 256'(2));
        if (hdr_ts.size() >= 2) check("t1_ts_delta", 256'(hdr_ts[1] - hdr_ts[0]), 256'(17));
        check("t1_seq_num", 256'(seq_num), 256'(2));

        // Random back-pressure with random gaps.
        ready_mode = 1;
        for (int p = 0; p < 4; p++) begin
            send_pkt(16, 1'b1, -1);
            idle();
            repeat ($urandom_range(0, 3)) @(posedge axis_aclk);
            #1;
        end
        drain("t2", nl);
        check("t2_tlasts", 256'(nl), 256'(4));
        ready_mode = 0;

        // Short packet followed by a clean one.
        send_pkt(10, 1'b1, -1);
        idle();
        send_pkt(16, 1'b1, -1);
        idle();
        drain("t3", nl);
        check("t3_err_short", 256'(err_short_cnt), 256'(1));

        // Overlong packet is trimmed, the tail dropped, next one clean.
        send_pkt(20, 1'b1, -1);
        idle();
        send_pkt(16, 1'b1, -1);
        idle();
        drain("t4", nl);
        check("t4_err_long", 256'(err_long_cnt), 256'(1));
        check("t4_tlasts", 256'(nl), 256'(2));

        // Disabled framer ignores offered data.
        enable      = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = {8{32'hDEAD_BEEF}};
        s_if.tlast  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge axis_aclk);
            check("t5_off_ready", 256'(s_if.tready), 256'(0));
            check("t5_off_busy", 256'(busy), 256'(0));
        end
        @(posedge axis_aclk);
        #1;
        idle();
        drain("t5_off", nl);

        // Dropping enable mid-packet lets that packet finish, nothing more.
        enable = 1'b1;
        send_pkt(16, 1'b1, 1);
        s_if.tvalid = 1'b1;
        s_if.tdata  = {8{32'h1234_5678}};
        s_if.tlast  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge axis_aclk);
            check("t5_mid_ready", 256'(s_if.tready), 256'(0));
        end
        @(posedge axis_aclk);
        #1;
        idle();
        drain("t5_mid", nl);
        check("t5_mid_tlasts", 256'(nl), 256'(1));
        enable = 1'b1;

        // Sequence number wrap.
        force dut.seq_q = 32'hFFFF_FFFF;
        @(posedge axis_aclk);
        #1;
        release dut.seq_q;
        m_seq = 32'hFFFF_FFFF;
        @(negedge axis_aclk);
        check("t6_seq_preload", 256'(seq_num), 256'(32'hFFFF_FFFF));
        @(posedge axis_aclk);
        #1;
        send_pkt(16, 1'b1, -1);
        send_pkt(16, 1'b1, -1);
        idle();
        drain("t6_wrap", nl);
        check("t6_seq_after", 256'(seq_num), 256'(1));

        // Short packet while the short counter is already saturated.
        force dut.err_short_q = 16'hFFFF;
        @(posedge axis_aclk);
        #1;
        release dut.err_short_q;
        m_short = 16'hFFFF;
        send_pkt(5, 1'b1, -1);
        idle();
        send_pkt(16, 1'b1, -1);
        idle();
        drain("t6_sat", nl);
        check("t6_sat_cnt", 256'(err_short_cnt), 256'(16'hFFFF));
        check("t6_sat_seq", 256'(seq_num), 256'(3));

        // Reset in the middle of a packet.
        send_beat(256'hA0, 1'b0);
        send_beat(256'hA1, 1'b0);
        send_beat(256'hA2, 1'b0);
        axis_rst = 1'b1;
        idle();
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("t7_m_tvalid", 256'(m_if.tvalid), 256'(0));
        check("t7_m_tlast", 256'(m_if.tlast), 256'(0));
        check("t7_m_tdata", m_if.tdata, 256'(0));
        check("t7_s_tready", 256'(s_if.tready), 256'(0));
        check("t7_seq", 256'(seq_num), 256'(0));
        check("t7_err", 256'({err_short_cnt, err_long_cnt}), 256'(0));
        check("t7_busy", 256'(busy), 256'(0));
        @(posedge axis_aclk);
        #1;
        axis_rst = 1'b0;
        out_q.delete();
        exp_q.delete();
        m_seq   = '0;
        m_short = '0;
        m_long  = '0;
        send_pkt(16, 1'b1, -1);
        idle();
        drain("t7_after", nl);
        check("t7_after_seq", 256'(seq_num), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
